// File: rtl/jogo_uart_rx.sv
// jogo_uart_rx: 8N1 UART receiver that assembles two bytes (high byte first)
// into one 16-bit word, {estado, macro, micro, res_macro, res_jogo}.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (default 434 = 50 MHz / 115200)
//   TIMEOUT_BITS  allowed inter-byte gap, in bit times (timeout build only)
//
// Ports:
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   s_in         serial line, idle high, LSB first
//   word         last complete word (changes only while valid is high)
//   estado       word[15:12]
//   macro        word[11:8]
//   micro        word[7:4]
//   res_macro    word[3:2]
//   res_jogo     word[1:0]
//   valid        one-cycle pulse when word updates
//   frame_error  one-cycle pulse on a bad stop bit or an inter-byte timeout
//   busy         high whenever the FSM is not in IDLE
//
// Build option:
//   JOGO_RX_TIMEOUT_EN  when defined, the wait for the second byte is bounded
//                       to TIMEOUT_BITS*CLKS_PER_BIT clocks; otherwise it is
//                       unbounded and no timeout counter exists.
module jogo_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s_in,
  output logic [15:0] word,
  output logic [3:0]  estado,
  output logic [3:0]  macro,
  output logic [3:0]  micro,
  output logic [1:0]  res_macro,
  output logic [1:0]  res_jogo,
  output logic        valid,
  output logic        frame_error,
  output logic        busy
);

  // Parameter sanity: the mid-start sample needs at least two clocks per bit.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("jogo_uart_rx: CLKS_PER_BIT must be >= 2");
  end
  if (TIMEOUT_BITS < 1) begin : g_bad_to
    $error("jogo_uart_rx: TIMEOUT_BITS must be >= 1");
  end

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);

`ifdef JOGO_RX_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
  localparam logic [GW-1:0] GAP_M1 = GW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [GW-1:0] gap_cnt;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t        state;
  logic          s_meta, s_sync, s_prev;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    hi_byte;
  logic          idx;       // 0: expecting high byte, 1: expecting low byte
  logic          from_gap;  // where a rejected start glitch returns to
  logic          fall;

  // s_prev keeps tracking the line in every state, so a line that is already
  // low when IDLE/GAP is entered cannot fake a start until it has gone high.
  assign fall = s_prev & ~s_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      s_meta      <= 1'b1;
      s_sync      <= 1'b1;
      s_prev      <= 1'b1;
      state       <= IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      hi_byte     <= '0;
      idx         <= 1'b0;
      from_gap    <= 1'b0;
      word        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
`ifdef JOGO_RX_TIMEOUT_EN
      gap_cnt     <= '0;
`endif
    end else begin
      s_meta      <= s_in;
      s_sync      <= s_meta;
      s_prev      <= s_sync;
      valid       <= 1'b0;
      frame_error <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            timer    <= '0;
            from_gap <= 1'b0;
          end
        end

        START: begin
          if (timer == HALF_M1) begin
            timer <= '0;
            if (!s_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Start bit gone by mid-bit: glitch, resume waiting silently.
              state <= from_gap ? GAP : IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DATA: begin
          if (timer == BIT_M1) begin
            timer   <= '0;
            shreg   <= {s_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        STOP: begin
          if (timer == BIT_M1) begin
            timer <= '0;
            if (s_sync) begin
              if (idx) begin
                word  <= {hi_byte, shreg};
                valid <= 1'b1;
                idx   <= 1'b0;
                state <= IDLE;
              end else begin
                hi_byte <= shreg;
                idx     <= 1'b1;
                state   <= GAP;
`ifdef JOGO_RX_TIMEOUT_EN
                gap_cnt <= '0;
`endif
              end
            end else begin
              frame_error <= 1'b1;
              idx         <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        GAP: begin
          if (fall) begin
            state    <= START;
            timer    <= '0;
            from_gap <= 1'b1;
          end
`ifdef JOGO_RX_TIMEOUT_EN
          // The gap count keeps running across a rejected glitch; it is only
          // restarted when a new high byte is accepted.
          else if (gap_cnt == GAP_M1) begin
            frame_error <= 1'b1;
            idx         <= 1'b0;
            state       <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign estado    = word[15:12];
  assign macro     = word[11:8];
  assign micro     = word[7:4];
  assign res_macro = word[3:2];
  assign res_jogo  = word[1:0];

endmodule

// File: tb/tb_jogo_uart_rx.sv
// Directed bench for jogo_uart_rx with CLKS_PER_BIT=4, TIMEOUT_BITS=20.
module tb_jogo_uart_rx;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        s_in;
  logic [15:0] word;
  logic [3:0]  estado, macro, micro;
  logic [1:0]  res_macro, res_jogo;
  logic        valid, frame_error, busy;

  int n_tests = 0;
  int n_fail  = 0;

  jogo_uart_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clock(clock), .reset(reset), .s_in(s_in), .word(word),
    .estado(estado), .macro(macro), .micro(micro),
    .res_macro(res_macro), .res_jogo(res_jogo),
    .valid(valid), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  // Monitor on the falling edge: pulse counts and protocol violations
  // (valid with frame_error, valid longer than one cycle, word moving
  // outside a valid cycle while not in reset).
  int          v_cnt = 0, fe_cnt = 0, proto_err = 0;
  logic [15:0] word_q = '0;
  logic        rst_q = 1'b1, valid_q = 1'b0;
  bit          busy_seen = 1'b0;

  always @(negedge clock) begin
    if (valid) v_cnt++;
    if (frame_error) fe_cnt++;
    if (valid && frame_error) proto_err++;
    if (valid && valid_q) proto_err++;
    if (!reset && !rst_q && !valid && word !== word_q) proto_err++;
    if (busy) busy_seen = 1'b1;
    word_q  = word;
    rst_q   = reset;
    valid_q = valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    s_in = 1'b1;
    repeat (n) cyc();
  endtask

  // Send one 8N1 frame. abort_at < 8 pulses reset two clocks into that bit.
  task automatic send(input logic [7:0] b, input logic stop, input int abort_at);
    s_in = 1'b0;
    repeat (CPB) cyc();
    for (int i = 0; i < 8; i++) begin
      s_in = b[i];
      if (i == abort_at) begin
        repeat (2) cyc();
        reset = 1'b1;
        s_in  = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        return;
      end
      repeat (CPB) cyc();
    end
    s_in = stop;
    repeat (CPB) cyc();
    s_in = 1'b1;
  endtask

  int v0, f0;

  initial begin
    reset = 1'b1;
    s_in  = 1'b1;
    repeat (3) cyc();
    chk("rst_word",  word, 0);
    chk("rst_valid", valid, 0);
    chk("rst_fe",    frame_error, 0);
    chk("rst_busy",  busy, 0);
    reset = 1'b0;
    idle(5);

    // Basic word
    v0 = v_cnt; f0 = fe_cnt;
    send(8'hA5, 1'b1, 8);
    send(8'h3C, 1'b1, 8);
    idle(10);
    chk("a5_nvalid",  v_cnt - v0, 1);
    chk("a5_nfe",     fe_cnt - f0, 0);
    chk("a5_word",    word, 16'hA53C);
    chk("a5_estado",  estado, 4'hA);
    chk("a5_macro",   macro, 4'h5);
    chk("a5_micro",   micro, 4'h3);
    chk("a5_resmac",  res_macro, 2'b11);
    chk("a5_resjogo", res_jogo, 2'b00);
    chk("a5_busy",    busy, 0);

    // Bad stop bit, then recovery
    v0 = v_cnt; f0 = fe_cnt;
    send(8'h12, 1'b0, 8);
    idle(10);
    chk("bad_nfe",    fe_cnt - f0, 1);
    chk("bad_nvalid", v_cnt - v0, 0);
    chk("bad_word",   word, 16'hA53C);
    send(8'h12, 1'b1, 8);
    send(8'h34, 1'b1, 8);
    idle(10);
    chk("rec_nvalid", v_cnt - v0, 1);
    chk("rec_word",   word, 16'h1234);
    chk("rec_nfe",    fe_cnt - f0, 1);

    // One-cycle glitch on an idle line
    v0 = v_cnt; f0 = fe_cnt;
    busy_seen = 1'b0;
    s_in = 1'b0;
    cyc();
    idle(12);
    chk("gl_seen",   busy_seen, 1);
    chk("gl_busy",   busy, 0);
    chk("gl_nvalid", v_cnt - v0, 0);
    chk("gl_nfe",    fe_cnt - f0, 0);

    // Reset in the middle of the low byte
    v0 = v_cnt; f0 = fe_cnt;
    send(8'hFF, 1'b1, 8);
    send(8'h0F, 1'b1, 4);
    chk("mr_word", word, 0);
    chk("mr_busy", busy, 0);
    idle(5);
    chk("mr_nvalid0", v_cnt - v0, 0);
    send(8'hFF, 1'b1, 8);
    send(8'h00, 1'b1, 8);
    idle(10);
    chk("mr_nvalid", v_cnt - v0, 1);
    chk("mr_word2",  word, 16'hFF00);
    chk("mr_nfe",    fe_cnt - f0, 0);

    // Long gap between bytes
    v0 = v_cnt; f0 = fe_cnt;
    send(8'h55, 1'b1, 8);
    idle(100);
    send(8'h66, 1'b1, 8);
    send(8'h77, 1'b1, 8);
    idle(10);
`ifdef JOGO_RX_TIMEOUT_EN
    chk("to_nfe",    fe_cnt - f0, 1);
    chk("to_nvalid", v_cnt - v0, 1);
    chk("to_word",   word, 16'h6677);
`else
    chk("gap_nfe",    fe_cnt - f0, 0);
    chk("gap_nvalid", v_cnt - v0, 1);
    chk("gap_word",   word, 16'h5566);
`endif

    chk("protocol", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jogo_uart_rx.md
JOGO_UART_RX -- requirements
Module: jogo_uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434; clock cycles per UART bit (50 MHz / 115200).
REQ-002 The block SHALL have parameter TIMEOUT_BITS, default 20; allowed gap in bit times between the two bytes of one word.
REQ-003 Port clock, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port s_in, input, 1: serial line, idle high, 8N1 with LSB first.
REQ-006 Port word, output, 16: last complete word, laid out as {estado, macro, micro, res_macro, res_jogo}.
REQ-007 Ports estado, macro and micro, outputs, 4 bits each: they SHALL equal word[15:12], word[11:8] and word[7:4].
REQ-008 Ports res_macro and res_jogo, outputs, 2 bits each: they SHALL equal word[3:2] and word[1:0].
REQ-009 Port valid, output, 1: one-cycle pulse when word updates.
REQ-010 Port frame_error, output, 1: one-cycle pulse on a bad stop bit or a timeout.
REQ-011 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-012 s_in SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and GAP.
- IDLE: a synchronized falling edge (1 then 0) SHALL go to START and clear the bit timer.
REQ-014 In START, the line SHALL be sampled at CLKS_PER_BIT/2 (integer division).
- Line 0: go to DATA with the timer reset.
- Line 1: treat as a glitch and return to the prior wait state (IDLE or GAP) with no error.
REQ-015 In DATA, 8 bits SHALL be sampled, one every CLKS_PER_BIT cycles, starting one full bit after the mid-start sample.
- Bits SHALL be shifted in LSB first.
- A 3-bit counter SHALL select STOP after bit 7.
REQ-016 In STOP, the line SHALL be sampled one bit time after bit 7.
- Line 1 = byte accepted.
- Line 0 = frame_error pulse, partial word discarded, byte index cleared, return to IDLE.
REQ-017 Byte order SHALL be high byte first.
- On an accepted byte with byte index 0: store it as the high byte, set index to 1, go to GAP.
- On an accepted byte with byte index 1: on the next clock, word = {high, low} and valid = 1 for exactly one cycle; index cleared; go to IDLE.
REQ-018 GAP SHALL behave as IDLE (start detection) while waiting for the second byte.
REQ-019 word and all field outputs SHALL change only in the valid cycle and SHALL hold otherwise.
REQ-020 Latency SHALL be exactly 1 clock from the stop-bit sample of the low byte to valid.
REQ-021 If the line is low during IDLE or GAP without a preceding high, no start SHALL be detected until the line has been seen high.
REQ-022 frame_error and valid SHALL never be asserted in the same cycle.

Reset
REQ-023 While reset is high, the following SHALL be cleared on the next clock edge:
- word = 0x0000, valid = 0, frame_error = 0, busy = 0;
- FSM = IDLE, byte index = 0, timers = 0;
- both synchronizer flops = 1.
REQ-024 A reset asserted mid-frame SHALL discard any partial byte or word; no valid or frame_error SHALL follow from it.

Configuration
REQ-025 Macro JOGO_RX_TIMEOUT_EN SHALL control the inter-byte timeout.
- Defined: GAP counts clocks; if no start is detected within TIMEOUT_BITS*CLKS_PER_BIT cycles, the block SHALL pulse frame_error, discard the high byte, clear the index and go to IDLE.
- Undefined: GAP waits indefinitely; the timeout counter SHALL be absent; TIMEOUT_BITS SHALL be unused.

Verification
REQ-026 The bench SHALL cover the following scenarios, all with CLKS_PER_BIT=4:
- Send bytes 0xA5 then 0x3C -> valid 1 cycle; word=0xA53C, estado=0xA, macro=0x5, micro=0x3, res_macro=2'b11, res_jogo=2'b00.
- Send 0x12 with stop bit 0 -> frame_error pulse, no valid, word unchanged; then send 0x12, 0x34 -> word=0x1234.
- Send a 1-cycle low glitch on an idle line -> no valid, no frame_error, busy returns to 0 within 3 cycles.
- Assert reset during bit 4 of the low byte, then send 0xFF, 0x00 -> only word=0xFF00 is reported.
- With JOGO_RX_TIMEOUT_EN, TIMEOUT_BITS=20: send 0x55, idle 100 cycles, then 0x66, 0x77 -> frame_error once, then word=0x6677.
- Without JOGO_RX_TIMEOUT_EN: same stimulus -> word=0x5566, no frame_error.
